// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM target.
package i2c_eeprom_pkg;

   typedef enum logic [3:0] {
      IDLE, CTRL, ACK_CTRL, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
      WDATA, ACK_W, RDATA, RACK, WAIT_STOP
   } state_t;

   localparam int ACK_BIT     = 8;   // bit counter value of the ACK slot
   localparam int CTRL_RW_BIT = 0;   // R/W flag position in the control byte

   // Ceiling log2, used to size the in-page part of the write pointer.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/i2c_eeprom_target_line_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP condition detection.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_l,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl_d, r_sda_d;
   logic                   w_scl, w_sda;

   assign w_scl = r_scl_sync[SYNC_STAGES-1];
   assign w_sda = r_sda_sync[SYNC_STAGES-1];

   // Synchroniser chains plus one delay stage for edge detection; idle bus is high.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   // SDA edges only count as bus conditions when SCL is stable high.
   assign o_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
   assign o_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

endmodule

// File: rtl/i2c_eeprom_target.sv
// 24Cxx-style EEPROM emulation on an I2C target: two address bytes,
// page-wrapping writes, full-space-wrapping sequential reads.
module i2c_eeprom_target
   import i2c_eeprom_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         ADDR_BITS   = 11,
   parameter int         PAGE_SIZE   = 32,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 sda_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 mem_we,
   output logic                 mem_re,
   input  logic [7:0]           mem_rdata,
   output logic                 busy,
   output logic                 wr_done
);

   localparam int PB = clog2(PAGE_SIZE);

   logic w_sda, w_rise, w_fall, w_start, w_stop;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .reset_l    (reset_l),
      .i_scl      (scl_i),
      .i_sda      (sda_i),
      .o_sda      (w_sda),
      .o_scl_rise (w_rise),
      .o_scl_fall (w_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   state_t                 r_st, w_st_n;
   logic [3:0]             r_cnt, w_cnt_n;
   logic [7:0]             r_shift, w_shift_n;
   logic [ADDR_BITS-1:0]   r_ptr, w_ptr_n;
   logic                   r_sda_oe, w_sda_oe_n;
   logic                   r_we, w_we_n;
   logic                   r_re, w_re_n;
   logic                   r_re_d;
   logic [ADDR_BITS-1:0]   r_addr, w_addr_n;
   logic [7:0]             r_wdata, w_wdata_n;
   logic                   r_busy, w_busy_n;
   logic                   r_wr_done, w_wr_done_n;
   logic                   r_wflag, w_wflag_n;
   logic                   r_rw, w_rw_n;

   logic [7:0]             w_byte;
   logic [PB-1:0]          w_pg_lo;
   logic [ADDR_BITS-1:0]   w_ptr_page;

   // Byte as it stands once the bit currently on SDA is shifted in.
   assign w_byte     = {r_shift[6:0], w_sda};
   // Writes only advance within the page; upper pointer bits hold.
   assign w_pg_lo    = r_ptr[PB-1:0] + PB'(1);
   assign w_ptr_page = {r_ptr[ADDR_BITS-1:PB], w_pg_lo};

   // State and datapath registers; reset returns everything to idle.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_st      <= IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_ptr     <= '0;
         r_sda_oe  <= 1'b0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_re_d    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_wr_done <= 1'b0;
         r_wflag   <= 1'b0;
         r_rw      <= 1'b0;
      end else begin
         r_st      <= w_st_n;
         r_cnt     <= w_cnt_n;
         r_shift   <= w_shift_n;
         r_ptr     <= w_ptr_n;
         r_sda_oe  <= w_sda_oe_n;
         r_we      <= w_we_n;
         r_re      <= w_re_n;
         r_re_d    <= r_re;
         r_addr    <= w_addr_n;
         r_wdata   <= w_wdata_n;
         r_busy    <= w_busy_n;
         r_wr_done <= w_wr_done_n;
         r_wflag   <= w_wflag_n;
         r_rw      <= w_rw_n;
      end
   end

   // Next-state and output decode; STOP beats START beats per-state bit handling.
   always_comb begin
      w_st_n      = r_st;
      w_cnt_n     = r_cnt;
      w_shift_n   = r_shift;
      w_ptr_n     = r_ptr;
      w_sda_oe_n  = r_sda_oe;
      w_we_n      = 1'b0;
      w_re_n      = 1'b0;
      w_addr_n    = r_addr;
      w_wdata_n   = r_wdata;
      w_busy_n    = r_busy;
      w_wr_done_n = 1'b0;
      w_wflag_n   = r_wflag;
      w_rw_n      = r_rw;

      // RAM data lands one clk after the read strobe.
      if (r_re_d) w_shift_n = mem_rdata;

      if (w_stop) begin
         w_st_n      = IDLE;
         w_sda_oe_n  = 1'b0;
         w_busy_n    = 1'b0;
         w_wr_done_n = r_wflag;
      end else if (w_start) begin
         w_st_n     = CTRL;
         w_cnt_n    = '0;
         w_sda_oe_n = 1'b0;
         w_wflag_n  = 1'b0;
      end else begin
         case (r_st)
            CTRL, ADDR_HI, ADDR_LO, WDATA: begin
               if (w_rise) begin
                  w_shift_n = w_byte;
                  w_cnt_n   = r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     case (r_st)
                        CTRL: begin
                           if (w_byte[7:1] == DEV_ADDR) begin
                              w_st_n   = ACK_CTRL;
                              w_busy_n = 1'b1;
                              w_rw_n   = w_byte[CTRL_RW_BIT];
                              // Current-address read: fetch now, ready by the ACK fall.
                              if (w_byte[CTRL_RW_BIT]) begin
                                 w_re_n   = 1'b1;
                                 w_addr_n = r_ptr;
                                 w_ptr_n  = r_ptr + ADDR_BITS'(1);
                              end
                           end else begin
                              w_st_n = WAIT_STOP;
                           end
                        end
                        ADDR_HI: begin
                           w_ptr_n[ADDR_BITS-1:8] = w_byte[ADDR_BITS-9:0];
                           w_st_n = ACK_HI;
                        end
                        ADDR_LO: begin
                           w_ptr_n[7:0] = w_byte;
                           w_st_n = ACK_LO;
                        end
                        default: begin
                           w_we_n    = 1'b1;
                           w_addr_n  = r_ptr;
                           w_wdata_n = w_byte;
                           w_ptr_n   = w_ptr_page;
                           w_wflag_n = 1'b1;
                           w_st_n    = ACK_W;
                        end
                     endcase
                  end
               end
            end
            ACK_CTRL, ACK_HI, ACK_LO, ACK_W: begin
               // First fall asserts the ACK, second fall ends the slot.
               if (w_fall) begin
                  if (!r_sda_oe) begin
                     w_sda_oe_n = 1'b1;
                  end else begin
                     w_sda_oe_n = 1'b0;
                     w_cnt_n    = '0;
                     case (r_st)
                        ACK_CTRL: begin
                           if (r_rw) begin
                              // Slot-ending fall also presents the first read bit.
                              w_sda_oe_n = ~r_shift[7];
                              w_shift_n  = {r_shift[6:0], 1'b0};
                              w_cnt_n    = 4'd1;
                              w_st_n     = RDATA;
                           end else begin
                              w_st_n = ADDR_HI;
                           end
                        end
                        ACK_HI:  w_st_n = ADDR_LO;
                        default: w_st_n = WDATA;
                     endcase
                  end
               end
            end
            RDATA: begin
               if (w_fall) begin
                  if (r_cnt == 4'(ACK_BIT)) begin
                     w_sda_oe_n = 1'b0;
                     w_st_n     = RACK;
                  end else begin
                     w_sda_oe_n = ~r_shift[7];
                     w_shift_n  = {r_shift[6:0], 1'b0};
                     w_cnt_n    = r_cnt + 4'd1;
                  end
               end
            end
            RACK: begin
               if (w_rise) begin
                  if (!w_sda) begin
                     w_re_n   = 1'b1;
                     w_addr_n = r_ptr;
                     w_ptr_n  = r_ptr + ADDR_BITS'(1);
                     w_cnt_n  = '0;
                     w_st_n   = RDATA;
                  end else begin
                     w_st_n = WAIT_STOP;
                  end
               end
            end
            WAIT_STOP: w_sda_oe_n = 1'b0;
            default: ;
         endcase
      end
   end

   assign sda_oe    = r_sda_oe;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_we    = r_we;
   assign mem_re    = r_re;
   assign busy      = r_busy;
   assign wr_done   = r_wr_done;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench: bit-banged I2C master, behavioural RAM, write log monitor.
module tb_i2c_eeprom_target;

   localparam int Q = 10;   // clks per quarter SCL period

   logic        clk = 1'b0;
   logic        reset_l = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_line;
   logic        sda_oe;
   logic [10:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we, mem_re;
   logic [7:0]  mem_rdata = 8'h00;
   logic        busy, wr_done;

   logic [7:0]  ram [0:2047];
   logic        tb_we = 1'b0;
   logic [10:0] tb_addr = '0;
   logic [7:0]  tb_data = '0;

   int n_vec = 0;
   int n_err = 0;

   int          we_cnt = 0, re_cnt = 0, wd_cnt = 0, oe_cnt = 0, busy_cnt = 0;
   logic [10:0] lg_a [0:31];
   logic [7:0]  lg_d [0:31];

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_eeprom_target dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .wr_done   (wr_done)
   );

   always @(posedge clk) begin
      if (tb_we) ram[tb_addr] <= tb_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_we) begin
         if (we_cnt < 32) begin
            lg_a[we_cnt] = mem_addr;
            lg_d[we_cnt] = mem_wdata;
         end
         we_cnt++;
      end
      if (mem_re)  re_cnt++;
      if (wr_done) wd_cnt++;
      if (sda_oe)  oe_cnt++;
      if (busy)    busy_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic hq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic poke(input logic [10:0] a, input logic [7:0] d);
      tb_addr = a; tb_data = d; tb_we = 1'b1;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; hq(); scl_m = 1'b1; hq(); sda_m = 1'b0; hq(); scl_m = 1'b0; hq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; hq(); scl_m = 1'b1; hq(); sda_m = 1'b1; hq();
   endtask

   task automatic clk_bit(input logic b, output logic s);
      sda_m = b; hq(); scl_m = 1'b1; hq(); s = sda_line; hq(); scl_m = 1'b0; hq();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(nack, s);
   endtask

   typedef struct {
      logic [7:0]       ahi;
      logic [7:0]       alo;
      int               n;
      logic [2:0][7:0]  d;
      logic [2:0][10:0] ea;
   } wvec_t;

   wvec_t wv [3];

   initial begin
      logic       ack, s;
      logic [7:0] rd;
      int         we0, wd0, re0, oe0, bz0;

      wv[0] = '{ahi: 8'h01, alo: 8'h23, n: 2, d: {8'h00, 8'h55, 8'hAA},
                 ea: {11'h000, 11'h124, 11'h123}};
      wv[1] = '{ahi: 8'h00, alo: 8'h3E, n: 3, d: {8'h33, 8'h22, 8'h11},
                 ea: {11'h020, 11'h03F, 11'h03E}};
      wv[2] = '{ahi: 8'hF9, alo: 8'hFF, n: 1, d: {8'h00, 8'h00, 8'h77},
                 ea: {11'h000, 11'h000, 11'h1FF}};

      repeat (4) @(negedge clk);
      chk("reset sda_oe",   32'(sda_oe),   32'h0);
      chk("reset busy",     32'(busy),     32'h0);
      chk("reset mem_addr", 32'(mem_addr), 32'h0);
      chk("reset mem_we",   32'(mem_we),   32'h0);
      chk("reset wr_done",  32'(wr_done),  32'h0);
      poke(11'h7FF, 8'hC3);
      poke(11'h000, 8'h3C);
      poke(11'h100, 8'h0F);
      reset_l = 1'b1;
      hq();

      // Table: page writes, in-page wrap, excess high address bits.
      for (int v = 0; v < 3; v++) begin
         we0 = we_cnt; wd0 = wd_cnt;
         i2c_start();
         send_byte(8'hA0, ack);     chk("wr ctrl ack", 32'(ack), 32'h1);
         send_byte(wv[v].ahi, ack); chk("wr ahi ack",  32'(ack), 32'h1);
         send_byte(wv[v].alo, ack); chk("wr alo ack",  32'(ack), 32'h1);
         chk("wr busy", 32'(busy), 32'h1);
         for (int k = 0; k < wv[v].n; k++) begin
            send_byte(wv[v].d[k], ack);
            chk("wr data ack", 32'(ack), 32'h1);
         end
         i2c_stop();
         repeat (4) @(negedge clk);
         chk("wr count", 32'(we_cnt - we0), 32'(wv[v].n));
         for (int k = 0; k < wv[v].n; k++) begin
            if (we0 + k < 32) begin
               chk("wr addr", 32'(lg_a[we0+k]), 32'(wv[v].ea[k]));
               chk("wr data", 32'(lg_d[we0+k]), 32'(wv[v].d[k]));
            end
         end
         chk("wr_done pulses", 32'(wd_cnt - wd0), 32'h1);
         chk("wr busy after stop", 32'(busy), 32'h0);
         chk("wr sda_oe idle", 32'(sda_oe), 32'h0);
      end

      // Random read across the top of the address space.
      we0 = we_cnt; wd0 = wd_cnt; re0 = re_cnt;
      i2c_start();
      send_byte(8'hA0, ack); chk("rr ctrl w ack", 32'(ack), 32'h1);
      send_byte(8'h07, ack); chk("rr ahi ack",    32'(ack), 32'h1);
      send_byte(8'hFF, ack); chk("rr alo ack",    32'(ack), 32'h1);
      i2c_start();
      send_byte(8'hA1, ack); chk("rr ctrl r ack", 32'(ack), 32'h1);
      recv_byte(1'b0, rd);   chk("rr byte0", 32'(rd), 32'hC3);
      recv_byte(1'b1, rd);   chk("rr byte1", 32'(rd), 32'h3C);
      chk("rr sda released", 32'(sda_oe), 32'h0);
      chk("rr busy", 32'(busy), 32'h1);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("rr reads", 32'(re_cnt - re0), 32'h2);
      chk("rr no writes", 32'(we_cnt - we0), 32'h0);
      chk("rr no wr_done", 32'(wd_cnt - wd0), 32'h0);
      chk("rr busy after stop", 32'(busy), 32'h0);

      // Control byte for another device address.
      we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt; bz0 = busy_cnt;
      i2c_start();
      send_byte(8'hA2, ack); chk("mm ctrl nack", 32'(ack), 32'h0);
      send_byte(8'h00, ack); chk("mm data nack", 32'(ack), 32'h0);
      chk("mm sda_oe cycles", 32'(oe_cnt - oe0), 32'h0);
      chk("mm busy cycles", 32'(busy_cnt - bz0), 32'h0);
      chk("mm strobes", 32'((we_cnt - we0) + (re_cnt - re0)), 32'h0);
      i2c_stop();

      // STOP in the middle of the first data byte.
      we0 = we_cnt; wd0 = wd_cnt;
      i2c_start();
      send_byte(8'hA0, ack); chk("ab ctrl ack", 32'(ack), 32'h1);
      send_byte(8'h02, ack); chk("ab ahi ack",  32'(ack), 32'h1);
      send_byte(8'h00, ack); chk("ab alo ack",  32'(ack), 32'h1);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("ab no write", 32'(we_cnt - we0), 32'h0);
      chk("ab no wr_done", 32'(wd_cnt - wd0), 32'h0);
      chk("ab busy", 32'(busy), 32'h0);
      chk("ab sda_oe", 32'(sda_oe), 32'h0);

      // Reset while a read is pulling SDA low, then a clean read from 0.
      i2c_start();
      send_byte(8'hA0, ack); chk("rs ctrl w ack", 32'(ack), 32'h1);
      send_byte(8'h01, ack);
      send_byte(8'h00, ack);
      i2c_start();
      send_byte(8'hA1, ack); chk("rs ctrl r ack", 32'(ack), 32'h1);
      chk("rs driving bit7 low", 32'(sda_oe), 32'h1);
      reset_l = 1'b0;
      #1;
      chk("rs async sda_oe", 32'(sda_oe), 32'h0);
      chk("rs async busy", 32'(busy), 32'h0);
      chk("rs async mem_addr", 32'(mem_addr), 32'h0);
      hq();
      sda_m = 1'b1; scl_m = 1'b1;
      hq();
      reset_l = 1'b1;
      hq();
      i2c_start();
      send_byte(8'hA1, ack); chk("rs post ctrl ack", 32'(ack), 32'h1);
      recv_byte(1'b1, rd);   chk("rs post byte", 32'(rd), 32'h3C);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("rs post busy", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
